fft_bitrev_buffer: RTL and testbench

// Downstream stage of cyclic-prefix removal in the OFDM receive chain.

---
 rtl/fft_bitrev_buffer.sv | 235 +++++++++++++++++++++++
 tb/tb_fft_bitrev_buffer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_buffer.sv
// Ping-pong symbol buffer between cyclic-prefix removal and a DIT radix-2 FFT.
// Symbols are written in natural order and replayed in bit-reversed address
// order through a 2-entry output skid buffer. Framing errors are flagged and
// emitted symbols are counted.
module fft_bitrev_buffer #(
  parameter int unsigned LOG2N = 6,
  parameter int unsigned DW    = 32
) (
  input  logic          ap_clk,
  input  logic          ap_rst_n,
  input  logic [DW-1:0] s_tdata,
  input  logic          s_tvalid,
  output logic          s_tready,
  input  logic          s_tlast,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tlast,
  output logic          err_short,
  output logic          err_long,
  output logic [15:0]   sym_count
);

  localparam int unsigned N  = 1 << LOG2N;
  localparam int unsigned AW = LOG2N + 1;
  localparam logic [LOG2N-1:0] LAST_IDX = {LOG2N{1'b1}};

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_RUN   = 2'd1,
    RD_DRAIN = 2'd2
  } rd_state_t;

  // Mirror the address bits to get the DIT input ordering.
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LOG2N; i++) begin
      r[i] = a[LOG2N-1-i];
    end
    return r;
  endfunction

  // Symbol storage: bank is the address MSB.
  logic [DW-1:0]    ram [0:2*N-1];
  logic [DW-1:0]    ram_q;

  // Write side
  logic [1:0]       full;
  logic [1:0]       full_nxt;
  logic             wr_bank;
  logic             wr_bank_nxt;
  logic [LOG2N-1:0] wr_cnt;
  logic [LOG2N-1:0] wr_cnt_nxt;
  logic             s_acc;
  logic             wr_en;
  logic             wr_done;
  logic             short_hit;
  logic [AW-1:0]    wr_addr;

  // Read side
  rd_state_t        state;
  rd_state_t        state_nxt;
  logic             rd_bank;
  logic [LOG2N-1:0] rd_cnt;
  logic [LOG2N-1:0] rd_cnt_nxt;
  logic             rd_en;
  logic             rd_done;
  logic [AW-1:0]    rd_addr;
  logic             rd_pend;
  logic             rd_pend_last;

  // Output skid buffer (head entry is the m_* register set)
  logic             spare_valid;
  logic [DW-1:0]    spare_data;
  logic             spare_last;
  logic             pop;
  logic [1:0]       occ;
  logic             can_issue;

  assign wr_addr = {wr_bank, wr_cnt};
  assign rd_addr = {rd_bank, bitrev(rd_cnt)};

  // Write-side next state: store, complete or drop a short symbol.
  always_comb begin
    s_acc       = s_tvalid && s_tready;
    wr_en       = 1'b0;
    wr_done     = 1'b0;
    short_hit   = 1'b0;
    wr_cnt_nxt  = wr_cnt;
    wr_bank_nxt = wr_bank;
    if (s_acc) begin
      if (s_tlast && (wr_cnt != LAST_IDX)) begin
        short_hit  = 1'b1;
        wr_cnt_nxt = '0;
      end else begin
        wr_en = 1'b1;
        if (wr_cnt == LAST_IDX) begin
          wr_done     = 1'b1;
          wr_cnt_nxt  = '0;
          wr_bank_nxt = ~wr_bank;
        end else begin
          wr_cnt_nxt = wr_cnt + LOG2N'(1);
        end
      end
    end
  end

  // Bank occupancy: write fills one bank while read frees the other.
  always_comb begin
    full_nxt = full;
    if (wr_done) full_nxt[wr_bank] = 1'b1;
    if (rd_done) full_nxt[rd_bank] = 1'b0;
  end

  // Write-side registers; ready looks ahead so a freed bank is usable at once.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_cnt    <= '0;
      wr_bank   <= 1'b0;
      full      <= '0;
      s_tready  <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      wr_cnt    <= wr_cnt_nxt;
      wr_bank   <= wr_bank_nxt;
      full      <= full_nxt;
      s_tready  <= ~full_nxt[wr_bank_nxt];
      err_short <= short_hit;
      err_long  <= wr_done && !s_tlast;
    end
  end

  // Skid credit: head + spare + in-flight read, less what leaves this cycle.
  always_comb begin
    pop       = m_tvalid && m_tready;
    rd_done   = pop && m_tlast;
    occ       = 2'(m_tvalid) + 2'(spare_valid) + 2'(rd_pend) - 2'(pop);
    can_issue = (occ < 2'd2);
  end

  // Read FSM next state; the first read issues on the IDLE->RUN transition.
  always_comb begin
    state_nxt  = state;
    rd_en      = 1'b0;
    rd_cnt_nxt = rd_cnt;
    case (state)
      RD_IDLE: begin
        if (full[rd_bank]) begin
          state_nxt = RD_RUN;
          rd_en     = can_issue;
        end
      end
      RD_RUN: begin
        rd_en = can_issue;
        if (can_issue && (rd_cnt == LAST_IDX)) state_nxt = RD_DRAIN;
      end
      RD_DRAIN: begin
        if (rd_done) state_nxt = RD_IDLE;
      end
      default: state_nxt = RD_IDLE;
    endcase
    if (rd_en) rd_cnt_nxt = rd_cnt + LOG2N'(1);
  end

  // Read FSM state, bank pointer and emitted-symbol counter.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= RD_IDLE;
      rd_cnt    <= '0;
      rd_bank   <= 1'b0;
      sym_count <= '0;
    end else begin
      state  <= state_nxt;
      rd_cnt <= rd_cnt_nxt;
      if (rd_done) begin
        rd_bank   <= ~rd_bank;
        sym_count <= sym_count + 16'd1;
      end
    end
  end

  // Dual-bank sample RAM with one-cycle synchronous read.
  always_ff @(posedge ap_clk) begin
    if (wr_en) ram[wr_addr] <= s_tdata;
    if (rd_en) ram_q <= ram[rd_addr];
  end

  // Tracks which RAM read result lands in the skid next cycle.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
    end else begin
      rd_pend      <= rd_en;
      rd_pend_last <= rd_en && (rd_cnt == LAST_IDX);
    end
  end

  // Two-entry skid: head holds steady while stalled, spare absorbs the in-flight read.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      m_tvalid    <= 1'b0;
      m_tdata     <= '0;
      m_tlast     <= 1'b0;
      spare_valid <= 1'b0;
      spare_data  <= '0;
      spare_last  <= 1'b0;
    end else if (pop) begin
      if (spare_valid) begin
        m_tdata     <= spare_data;
        m_tlast     <= spare_last;
        spare_valid <= rd_pend;
        if (rd_pend) begin
          spare_data <= ram_q;
          spare_last <= rd_pend_last;
        end
      end else begin
        m_tvalid <= rd_pend;
        m_tlast  <= rd_pend && rd_pend_last;
        if (rd_pend) m_tdata <= ram_q;
      end
    end else if (!m_tvalid) begin
      m_tvalid <= rd_pend;
      m_tlast  <= rd_pend && rd_pend_last;
      if (rd_pend) m_tdata <= ram_q;
    end else if (rd_pend) begin
      spare_valid <= 1'b1;
      spare_data  <= ram_q;
      spare_last  <= rd_pend_last;
    end
  end

endmodule

// File: tb/tb_fft_bitrev_buffer.sv
// Self-checking bench for fft_bitrev_buffer: a queue-based reference model
// predicts every output sample, error pulse and symbol count.
module tb_fft_bitrev_buffer;

  localparam int LOG2N = 6;
  localparam int DW    = 32;
  localparam int N     = 1 << LOG2N;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic          err_short;
  logic          err_long;
  logic [15:0]   sym_count;

  always #5 ap_clk = ~ap_clk;

  fft_bitrev_buffer #(.LOG2N(LOG2N), .DW(DW)) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tlast   (s_tlast),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast),
    .err_short (err_short),
    .err_long  (err_long),
    .sym_count (sym_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reverse the LOG2N-digit binary representation of i arithmetically.
  function automatic int rev_idx(input int i);
    int r = 0;
    int v = i;
    for (int b = 0; b < LOG2N; b++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  // Reference model state
  logic [DW-1:0] cur_q[$];
  logic [DW-1:0] exp_q[$];
  bit            exp_last_q[$];
  logic [DW-1:0] out_log[$];
  bit            exp_short_nxt, exp_long_nxt;
  int            short_seen, long_seen, acc_total, out_total, sym_model;
  int            stall_run, max_stall, done_edge, first_valid;
  bit            prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  // Monitor: outputs are sampled on the falling edge, handshakes complete on the next rising edge.
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      cur_q.delete(); exp_q.delete(); exp_last_q.delete(); out_log.delete();
      exp_short_nxt = 0; exp_long_nxt = 0;
      short_seen = 0; long_seen = 0; acc_total = 0; out_total = 0; sym_model = 0;
      stall_run = 0; max_stall = 0; done_edge = -1; first_valid = -1;
      prev_stall = 0;
    end else begin
      check("err_short", err_short, exp_short_nxt);
      check("err_long", err_long, exp_long_nxt);
      check("sym_count", sym_count, 16'(sym_model));
      if (err_short) short_seen++;
      if (err_long) long_seen++;
      if (prev_stall) begin
        check("stall_valid", m_tvalid, 1);
        check("stall_data", m_tdata, prev_data);
        check("stall_last", m_tlast, prev_last);
      end
      if (m_tvalid && first_valid < 0) first_valid = cyc;
      if (m_tvalid) check("valid_without_symbol", exp_q.size() != 0, 1);
      if (m_tvalid && m_tready && exp_q.size() != 0) begin
        check("m_tdata", m_tdata, exp_q[0]);
        check("m_tlast", m_tlast, exp_last_q[0]);
        if (exp_last_q[0]) sym_model++;
        out_log.push_back(m_tdata);
        void'(exp_q.pop_front());
        void'(exp_last_q.pop_front());
        out_total++;
      end
      exp_short_nxt = 0;
      exp_long_nxt  = 0;
      if (s_tvalid && s_tready) begin
        acc_total++;
        if (s_tlast && cur_q.size() < N - 1) begin
          exp_short_nxt = 1;
          cur_q.delete();
        end else begin
          cur_q.push_back(s_tdata);
          if (cur_q.size() == N) begin
            exp_long_nxt = !s_tlast;
            for (int i = 0; i < N; i++) begin
              exp_q.push_back(cur_q[rev_idx(i)]);
              exp_last_q.push_back(i == N - 1);
            end
            cur_q.delete();
            done_edge = cyc + 1;
          end
        end
      end
      if (s_tvalid && !s_tready) stall_run++; else stall_run = 0;
      if (stall_run > max_stall) max_stall = stall_run;
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
    end
  end

  // Downstream ready generator: 0 always-ready, 1 pattern 1,0,0,1, 2 stalled, 3 random.
  int rdy_mode = 0;
  int rcyc = 0;
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge ap_clk);
      #1;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = (rcyc % 4 == 0) || (rcyc % 4 == 3);
        2:       m_tready = 1'b0;
        default: m_tready = ($urandom_range(0, 3) != 0);
      endcase
      rcyc++;
    end
  end

  task automatic wait_accept(output bit ok);
    bit acc;
    int t;
    ok = 0;
    for (t = 0; t < 3000; t++) begin
      @(negedge ap_clk);
      acc = s_tready && ap_rst_n;
      @(posedge ap_clk);
      #1;
      if (acc) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("accept_within_bound", t < 3000, 1);
  endtask

  task automatic send_symbol(input int len, input bit with_last, input bit rnd,
                             input bit gaps, input int base, output bit ok);
    ok = 1;
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge ap_clk);
        #1;
      end
      s_tdata  = rnd ? DW'($urandom) : DW'(base + i);
      s_tlast  = with_last && (i == len - 1);
      s_tvalid = 1'b1;
      wait_accept(ok);
      if (!ok) break;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    for (t = 0; t < 4000; t++) begin
      @(negedge ap_clk);
      if (exp_q.size() == 0 && !m_tvalid) break;
    end
    check({name, "_drained"}, t < 4000, 1);
    repeat (4) @(negedge ap_clk);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_s_tready"}, s_tready, 0);
    check({name, "_m_tvalid"}, m_tvalid, 0);
    check({name, "_m_tdata"}, m_tdata, 0);
    check({name, "_m_tlast"}, m_tlast, 0);
    check({name, "_err_short"}, err_short, 0);
    check({name, "_err_long"}, err_long, 0);
    check({name, "_sym_count"}, sym_count, 0);
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    ap_rst_n = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    check_outputs_zero("rst");
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    check("s_tready_after_release", s_tready, 1);
  endtask

  typedef struct {
    int nsym;
    int short_len;
    bit with_last;
    int rdy;
    bit rnd;
    bit gaps;
    bit chk_stall;
    int exp_sym;
    int exp_short;
    int exp_long;
  } scen_t;

  scen_t tbl[6];
  int    first_vals[6];
  bit    ok;
  bit    sender_done;
  int    t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{nsym: 8, short_len: 0,  with_last: 1, rdy: 0, rnd: 0, gaps: 0, chk_stall: 1, exp_sym: 8, exp_short: 0, exp_long: 0};
    tbl[1] = '{nsym: 2, short_len: 0,  with_last: 1, rdy: 1, rnd: 0, gaps: 0, chk_stall: 0, exp_sym: 2, exp_short: 0, exp_long: 0};
    tbl[2] = '{nsym: 1, short_len: 11, with_last: 1, rdy: 0, rnd: 0, gaps: 0, chk_stall: 0, exp_sym: 1, exp_short: 1, exp_long: 0};
    tbl[3] = '{nsym: 1, short_len: 0,  with_last: 0, rdy: 0, rnd: 0, gaps: 0, chk_stall: 0, exp_sym: 1, exp_short: 0, exp_long: 1};
    tbl[4] = '{nsym: 6, short_len: 0,  with_last: 1, rdy: 3, rnd: 1, gaps: 1, chk_stall: 0, exp_sym: 6, exp_short: 0, exp_long: 0};
    tbl[5] = '{nsym: 4, short_len: 23, with_last: 1, rdy: 3, rnd: 1, gaps: 1, chk_stall: 0, exp_sym: 4, exp_short: 1, exp_long: 0};
    first_vals = '{0, 32, 16, 48, 8, 40};

    // Single ramp symbol: order, latency and count.
    rdy_mode = 0;
    do_reset();
    send_symbol(N, 1, 0, 0, 0, ok);
    drain("ramp");
    check("first_valid_latency", first_valid - done_edge, 2);
    check("ramp_out_count", out_log.size(), N);
    for (int i = 0; i < 6; i++) check($sformatf("ramp_out%0d", i), out_log[i], first_vals[i]);
    check("ramp_out63", out_log[N-1], N - 1);
    check("ramp_sym_count", sym_count, 1);

    // Table of framing / backpressure scenarios.
    for (int k = 0; k < 6; k++) begin
      rdy_mode = tbl[k].rdy;
      do_reset();
      if (tbl[k].short_len > 0) send_symbol(tbl[k].short_len, 1, tbl[k].rnd, tbl[k].gaps, 7000, ok);
      for (int s = 0; s < tbl[k].nsym; s++)
        send_symbol(N, tbl[k].with_last, tbl[k].rnd, tbl[k].gaps, s * N, ok);
      drain($sformatf("s%0d", k));
      check($sformatf("s%0d_sym_count", k), sym_count, tbl[k].exp_sym);
      check($sformatf("s%0d_err_short_count", k), short_seen, tbl[k].exp_short);
      check($sformatf("s%0d_err_long_count", k), long_seen, tbl[k].exp_long);
      check($sformatf("s%0d_out_count", k), out_total, tbl[k].exp_sym * N);
      if (tbl[k].chk_stall) check($sformatf("s%0d_ready_low_le3", k), max_stall <= 3, 1);
    end

    // Downstream fully stalled: both banks fill, then release.
    rdy_mode = 2;
    do_reset();
    sender_done = 0;
    fork
      begin
        bit okb;
        for (int s = 0; s < 3; s++) send_symbol(N, 1, 0, 0, 500 + s * N, okb);
        sender_done = 1;
      end
    join_none
    for (t = 0; t < 1000; t++) begin
      @(negedge ap_clk);
      if (acc_total >= 2 * N) break;
    end
    repeat (20) @(negedge ap_clk);
    check("bp_accepted", acc_total, 2 * N);
    check("bp_s_tready", s_tready, 0);
    check("bp_m_tvalid", m_tvalid, 1);
    rdy_mode = 0;
    for (t = 0; t < 2000; t++) begin
      @(negedge ap_clk);
      if (sender_done) break;
    end
    check("bp_sender_done", sender_done, 1);
    drain("bp");
    check("bp_sym_count", sym_count, 3);
    check("bp_out_count", out_total, 3 * N);

    // Reset mid-output of symbol 1 while symbol 2 is half written.
    rdy_mode = 0;
    do_reset();
    send_symbol(N, 1, 0, 0, 100, ok);
    send_symbol(N / 2, 0, 0, 0, 300, ok);
    check("mid_m_tvalid", m_tvalid, 1);
    check("mid_partial_output", (out_total > 0) && (out_total < N), 1);
    ap_rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    do_reset();
    repeat (10) @(negedge ap_clk);
    check("post_rst_idle", m_tvalid, 0);
    send_symbol(N, 1, 0, 0, 900, ok);
    drain("post_rst");
    check("post_rst_sym_count", sym_count, 1);
    check("post_rst_out_count", out_total, N);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
